// File: rtl/servo_ramp_ctrl.sv
// Servo pulse-width scheduler: accepts per-channel targets/steps and, once per frame,
// walks every channel moving its driven width one step toward its target.
module servo_ramp_ctrl #(
    parameter int NCH          = 4,
    parameter int FRAME_CYCLES = 2000000,
    parameter int MIN_W        = 100,
    parameter int MAX_W        = 200,
    parameter int CENTER_W     = 150,
    localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CW-1:0]       cmd_ch,
    input  logic [10:0]         cmd_target,
    input  logic [7:0]          cmd_step,
    output logic [NCH*11-1:0]   width_out,
    output logic [NCH-1:0]      moving,
    output logic                frame_tick
);

    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] IDX_LAST   = CW'(NCH - 1);
    localparam logic [10:0]   MIN_V      = 11'(MIN_W);
    localparam logic [10:0]   MAX_V      = 11'(MAX_W);
    localparam logic [10:0]   CTR_V      = 11'(CENTER_W);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  idx, idx_nxt;
    logic           upd_en;
    logic [FW-1:0]  frame_cnt;
    logic           cmd_fire;
    logic           ch_ok;
    logic [10:0]    tgt_clamped;

    logic [10:0]    target [NCH];
    logic [7:0]     step   [NCH];
    logic [10:0]    width  [NCH];

    logic [10:0]        cur_t, cur_w, next_w;
    logic [7:0]         cur_s;
    logic signed [11:0] diff;
    logic [11:0]        mag;

    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_cnt == FRAME_LAST)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign frame_tick = !rst && (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        upd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt = UPDATE;
                    idx_nxt   = '0;
                end
            end
            UPDATE: begin
                upd_en  = 1'b1;
                idx_nxt = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Non-power-of-two channel counts leave encodable but nonexistent channels.
    generate
        if ((1 << CW) == NCH) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = ({1'b0, cmd_ch} < (CW + 1)'(NCH));
        end
    endgenerate

    always_comb begin
        tgt_clamped = cmd_target;
        if (cmd_target < MIN_V)
            tgt_clamped = MIN_V;
        else if (cmd_target > MAX_V)
            tgt_clamped = MAX_V;
    end

    always_comb begin
        cur_t  = target[idx];
        cur_w  = width[idx];
        cur_s  = step[idx];
        diff   = $signed({1'b0, cur_t}) - $signed({1'b0, cur_w});
        mag    = diff[11] ? 12'(-diff) : 12'(diff);
        next_w = cur_t;
        // Targets are always clamped, so stepping toward one can never leave range.
        if (cur_s != 8'd0 && mag > {4'b0, cur_s}) begin
            if (diff[11])
                next_w = cur_w - {3'b0, cur_s};
            else
                next_w = cur_w + {3'b0, cur_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                target[i] <= CTR_V;
                step[i]   <= 8'd0;
                width[i]  <= CTR_V;
            end
        end else begin
            if (cmd_fire && ch_ok) begin
                target[cmd_ch] <= tgt_clamped;
                step[cmd_ch]   <= cmd_step;
            end
            if (upd_en)
                width[idx] <= next_w;
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_out
            assign width_out[11*g +: 11] = width[g];
            assign moving[g]             = (width[g] != target[g]);
        end
    endgenerate

endmodule
